// File: rtl/id_ex_issue.sv
// id_ex_issue -- ID/EX pipeline register and issue controller.
//
// Captures a decoded instruction from ID under a valid/ready handshake and
// drives the EX math-unit inputs. A MUL is held stable for MUL_LAT cycles so
// the combinational multiplier settles before the result is offered to EX/MEM.
//
// Parameters:
//   MUL_LAT  cycles a MUL occupies EX (1..15, checked at elaboration)
// Optional build macro:
//   ID_EX_FWD_EN  operand forwarding from EX/MEM and MEM/WB at capture
//                 (XZR, then EX/MEM, then MEM/WB, then the register-file value)
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous squash of the held instruction
//   in_valid / in_ready     ID handshake (in_ready is combinational)
//   in_op .. in_pc          decoded instruction fields
//   out_ready / out_valid   EX/MEM handshake
//   ex_*                    registered EX inputs and held fields
//   mul_busy                high while a MUL is settling
//   fwd_*                   forwarding sources (used only with ID_EX_FWD_EN)
module id_ex_issue #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_signed,
  input  logic [5:0]  in_shamt,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [4:0]  in_rd,
  input  logic [63:0] in_opA,
  input  logic [63:0] in_opB,
  input  logic        in_reg_write,
  input  logic [63:0] in_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] ex_A,
  output logic [63:0] ex_B,
  output logic        ex_doSigned,
  output logic        ex_direction,
  output logic [5:0]  ex_distance,
  output logic [1:0]  ex_op,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic [63:0] ex_pc,
  output logic        mul_busy,
  input  logic        fwd_mem_we,
  input  logic        fwd_wb_we,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [63:0] fwd_mem_data,
  input  logic [63:0] fwd_wb_data
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $fatal(1, "id_ex_issue: MUL_LAT must be in 1..15");
  end

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b11;
  localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    FULL     = 2'b01,
    MUL_WAIT = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture;
  logic [63:0] op_a, op_b;

`ifdef ID_EX_FWD_EN
  function automatic logic [63:0] fwd_sel(
    input logic [4:0]  rs,
    input logic [63:0] rf_val,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [63:0] mem_data,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [63:0] wb_data
  );
    if (rs == 5'd31)                 return '0;
    else if (mem_we && mem_rd == rs) return mem_data;
    else if (wb_we && wb_rd == rs)   return wb_data;
    else                             return rf_val;
  endfunction

  assign op_a = fwd_sel(in_rn, in_opA, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign op_b = fwd_sel(in_rm, in_opB, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                        fwd_wb_we, fwd_wb_rd, fwd_wb_data);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_mem_we, fwd_wb_we, fwd_mem_rd, fwd_wb_rd,
                        fwd_mem_data, fwd_wb_data, in_rn, in_rm};
  assign op_a = in_opA;
  assign op_b = in_opB;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    if (!flush) begin
      case (state)
        EMPTY:   in_ready = 1'b1;
        FULL:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
    capture = in_valid && in_ready;

    if (flush) begin
      state_nxt = EMPTY;
      cnt_nxt   = '0;
    end else begin
      case (state)
        EMPTY, FULL: begin
          if (capture) begin
            if (in_op == OP_MUL && MUL_LAT > 1) begin
              state_nxt = MUL_WAIT;
              cnt_nxt   = LAT_M1;
            end else begin
              state_nxt = FULL;
            end
          end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
          end
        end
        MUL_WAIT: begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = FULL;
        end
        default: begin
          state_nxt = EMPTY;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Data registers load only on capture; flush leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_A         <= '0;
      ex_B         <= '0;
      ex_doSigned  <= 1'b0;
      ex_direction <= 1'b0;
      ex_distance  <= '0;
      ex_op        <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_pc        <= '0;
    end else if (capture) begin
      ex_A         <= op_a;
      ex_B         <= op_b;
      ex_doSigned  <= in_signed && (in_op == OP_MUL);
      ex_direction <= (in_op == OP_LSR);
      ex_distance  <= in_shamt;
      ex_op        <= in_op;
      ex_rd        <= in_rd;
      ex_reg_write <= in_reg_write;
      ex_pc        <= in_pc;
    end
  end

  assign out_valid = (state == FULL);
  assign mul_busy  = (state == MUL_WAIT);

endmodule

// File: tb/tb_id_ex_issue.sv
module tb_id_ex_issue;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_signed;
  logic [5:0]  in_shamt;
  logic [4:0]  in_rn, in_rm, in_rd;
  logic [63:0] in_opA, in_opB;
  logic        in_reg_write;
  logic [63:0] in_pc;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] ex_A, ex_B;
  logic        ex_doSigned, ex_direction;
  logic [5:0]  ex_distance;
  logic [1:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic [63:0] ex_pc;
  logic        mul_busy;
  logic        fwd_mem_we, fwd_wb_we;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [63:0] fwd_mem_data, fwd_wb_data;

  id_ex_issue #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_signed(in_signed), .in_shamt(in_shamt),
    .in_rn(in_rn), .in_rm(in_rm), .in_rd(in_rd),
    .in_opA(in_opA), .in_opB(in_opB),
    .in_reg_write(in_reg_write), .in_pc(in_pc),
    .out_ready(out_ready), .out_valid(out_valid),
    .ex_A(ex_A), .ex_B(ex_B), .ex_doSigned(ex_doSigned),
    .ex_direction(ex_direction), .ex_distance(ex_distance),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc),
    .mul_busy(mul_busy),
    .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One instruction in flight: cap = edge that loads it, due = first cycle
  // it should be offered to EX/MEM.
  typedef struct {
    int          cap;
    int          due;
    logic [63:0] a;
    logic [63:0] b;
    logic [15:0] ctrl;
    logic [63:0] pc;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] src_val(input logic [4:0] rs, input logic [63:0] rf);
`ifdef ID_EX_FWD_EN
    if (rs == 5'd31) return 64'd0;
    if (fwd_mem_we && fwd_mem_rd == rs) return fwd_mem_data;
    if (fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
`endif
    return rf;
  endfunction

  function automatic item_t make_item();
    item_t it;
    int lat;
    lat     = (in_op == 2'b01) ? LAT : 1;
    it.cap  = cyc + 1;
    it.due  = cyc + lat;
    it.a    = src_val(in_rn, in_opA);
    it.b    = src_val(in_rm, in_opB);
    it.ctrl = {in_signed && in_op == 2'b01, in_op == 2'b11, in_shamt, in_op, in_rd, in_reg_write};
    it.pc   = in_pc;
    return it;
  endfunction

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    logic er;
    #1;
    er = !flush && (q.size() == 0 || (cyc >= q[0].due && out_ready));
    chk("in_ready", {63'd0, in_ready}, {63'd0, er});
    if (in_valid && er) q.push_back(make_item());
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic sgn, input logic [5:0] sh,
                        input logic [4:0] rn, input logic [4:0] rm,
                        input logic [63:0] a, input logic [63:0] b);
    in_op = op; in_signed = sgn; in_shamt = sh; in_rn = rn; in_rm = rm;
    in_opA = a; in_opB = b;
    in_rd = 5'($urandom); in_reg_write = 1'($urandom); in_pc = {$urandom, $urandom};
  endtask

  task automatic chk_zero_outputs();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mul_busy", {63'd0, mul_busy}, 64'd0);
    chk("rst_ex_A", ex_A, 64'd0);
    chk("rst_ex_B", ex_B, 64'd0);
    chk("rst_ex_ctrl", {48'd0, ex_doSigned, ex_direction, ex_distance, ex_op, ex_rd, ex_reg_write}, 64'd0);
    chk("rst_ex_pc", ex_pc, 64'd0);
  endtask

  // Monitor: model-derived valid/busy timing, held fields compared every
  // cycle the instruction is inside the block.
  always @(negedge clk) begin
    bit live, ev, eb;
    if (reset_n && mon_en) begin
      live = q.size() > 0 && cyc >= q[0].cap;
      ev   = live && cyc >= q[0].due;
      eb   = live && cyc < q[0].due;
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("mul_busy", {63'd0, mul_busy}, {63'd0, eb});
      if (live) begin
        chk("ex_A", ex_A, q[0].a);
        chk("ex_B", ex_B, q[0].b);
        chk("ex_ctrl", {48'd0, ex_doSigned, ex_direction, ex_distance, ex_op, ex_rd, ex_reg_write},
            {48'd0, q[0].ctrl});
        chk("ex_pc", ex_pc, q[0].pc);
      end
      if (ev && out_ready) void'(q.pop_front());
      else if (flush && live) void'(q.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_in(2'b00, 1'b0, 6'd0, 5'd0, 5'd0, 64'd0, 64'd0);
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; fwd_mem_rd = '0; fwd_wb_rd = '0;
    fwd_mem_data = '0; fwd_wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs();
    reset_n = 1'b1;
    #1;
    chk_zero_outputs();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    mon_en = 1;

    // ALU-pass 5/7
    out_ready = 1'b1; in_valid = 1'b1;
    set_in(2'b00, 1'b0, 6'd0, 5'd1, 5'd2, 64'd5, 64'd7);
    step();
    in_valid = 1'b0;
    repeat (2) step();

    // signed MUL -1 * 1, ALU pressing behind it
    in_valid = 1'b1;
    set_in(2'b01, 1'b1, 6'd0, 5'd4, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step();
    set_in(2'b00, 1'b1, 6'd9, 5'd6, 5'd7, 64'd11, 64'd12);
    repeat (4) step();
    in_valid = 1'b0;
    repeat (3) step();

    // LSR 63 stalled 4 cycles, then back-to-back capture
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(2'b11, 1'b0, 6'd63, 5'd8, 5'd9, 64'h8000_0000_0000_0001, 64'd3);
    step();
    set_in(2'b10, 1'b0, 6'd1, 5'd10, 5'd11, 64'd21, 64'd22);
    repeat (4) step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // flush in MUL_WAIT with in_valid high
    in_valid = 1'b1;
    set_in(2'b01, 1'b0, 6'd0, 5'd12, 5'd13, 64'd99, 64'd100);
    step();
    flush = 1'b1;
    set_in(2'b00, 1'b0, 6'd0, 5'd14, 5'd15, 64'd1, 64'd2);
    step();
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) step();

`ifdef ID_EX_FWD_EN
    // EX/MEM wins over MEM/WB; XZR wins over EX/MEM
    in_valid = 1'b1;
    set_in(2'b00, 1'b0, 6'd0, 5'd3, 5'd5, 64'd1, 64'd2);
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 64'hAA;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 64'hBB;
    step();
    set_in(2'b00, 1'b0, 6'd0, 5'd7, 5'd31, 64'd1, 64'd2);
    fwd_mem_rd = 5'd31;
    step();
    in_valid = 1'b0; fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
    repeat (2) step();
`endif

    // reset mid-MUL
    in_valid = 1'b1;
    set_in(2'b01, 1'b1, 6'd5, 5'd16, 5'd17, 64'h1234, 64'h5678);
    step();
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs();
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      set_in(2'($urandom), 1'($urandom), 6'($urandom),
             ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
             {$urandom, $urandom}, {$urandom, $urandom});
      fwd_mem_we = 1'($urandom); fwd_wb_we = 1'($urandom);
      fwd_mem_rd = 5'($urandom_range(0, 3)); fwd_wb_rd = 5'($urandom_range(0, 3));
      fwd_mem_data = {$urandom, $urandom}; fwd_wb_data = {$urandom, $urandom};
      step();
    end

    // drain
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (LAT + 3) step();
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

ID/EX pipeline register and issue controller for the execute stage. It captures decoded operands from ID under a valid/ready handshake and drives the EX math-unit inputs (multiplier A/B/doSigned, shifter value/direction/distance). A MUL is held stable for MUL_LAT cycles so the combinational multiplier settles before the result is marked valid to EX/MEM. Optional operand forwarding from EX/MEM and MEM/WB is applied at capture.

## Interface
- MUL_LAT, 2: cycles a MUL occupies EX; legal 1..15.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of the held instruction
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  block accepts this cycle (combinational)
- in_op  in  2  00 ALU-pass, 01 MUL, 10 LSL, 11 LSR
- in_signed  in  1  signed multiply request
- in_shamt  in  6  shift distance
- in_rn, in_rm, in_rd  in  5  source and destination register numbers
- in_opA, in_opB  in  64  register-file operand values
- in_reg_write  in  1  instruction writes rd
- in_pc  in  64  instruction PC
- out_ready  in  1  EX/MEM accepts this cycle
- out_valid  out  1  EX inputs stable and result consumable
- ex_A, ex_B  out  64  operands to multiplier/ALU; ex_A also shifter value
- ex_doSigned  out  1  held in_signed, forced 0 when op≠MUL
- ex_direction  out  1  1 iff op==LSR
- ex_distance  out  6  held shamt
- ex_op  out  2, ex_rd  out  5, ex_reg_write  out  1, ex_pc  out  64  held fields
- mul_busy  out  1  high in MUL_WAIT
- fwd_mem_we, fwd_wb_we  in  1  forwarding-source write enables (FWD_EN only)
- fwd_mem_rd, fwd_wb_rd  in  5; fwd_mem_data, fwd_wb_data  in  64

## Operation
- States: EMPTY, FULL, MUL_WAIT; 4-bit down counter cnt.
- in_ready = !flush && (EMPTY || (FULL && out_ready)); always 0 in MUL_WAIT.
- Capture when in_valid && in_ready: all in_* fields registered, ex_direction/ex_doSigned derived at capture.
- Next state on capture: MUL with MUL_LAT>1 -> MUL_WAIT, cnt=MUL_LAT-1; otherwise FULL.
- MUL_WAIT: cnt decrements each cycle; at cnt==1 the next state is FULL. Registered outputs are frozen.
- FULL with out_ready and no capture -> EMPTY. FULL with out_ready and capture -> back-to-back load, with no bubble.
- FULL with !out_ready: hold all outputs.
- out_valid = (state==FULL).
- flush has top priority in every state: next state EMPTY, cnt=0, no capture. Data registers keep their values; out_valid drops the next cycle.
- Arithmetic: cnt is 4-bit. MUL_LAT is checked at elaboration; a value outside 1..15 is a fatal error.

## Timing
- Reset (async assert, sync-safe release): state EMPTY, cnt 0, out_valid 0, mul_busy 0, all ex_* 0. in_ready reads 1 after reset unless flush.
- Non-MUL: captured at edge N, out_valid high from N+1.
- MUL: captured at edge N, mul_busy high N+1..N+MUL_LAT-1, out_valid high from N+MUL_LAT.
- Throughput: 1 instr/cycle for non-MUL while out_ready is high; one MUL per MUL_LAT cycles.
- reset_n asserted mid-MUL_WAIT: immediate EMPTY; the instruction is lost by design.

## Configuration
- ID_EX_FWD_EN defined: at capture, each operand's source register is checked in this order:
  - rs==31: the operand is 0 (XZR).
  - else fwd_mem_we && fwd_mem_rd==rs: the operand is fwd_mem_data.
  - else fwd_wb_we && fwd_wb_rd==rs: the operand is fwd_wb_data.
  - else the operand is in_opA/in_opB.
  - rn selects ex_A; rm selects ex_B.
- ID_EX_FWD_EN undefined: in_opA/in_opB are captured unchanged and the fwd_* ports are ignored.
- Forwarding is applied only at capture, never while holding.

## Test plan
- Reset, then ALU-pass capture of opA=5, opB=7 with out_ready=1 -> out_valid high next cycle, ex_A=5, ex_B=7, ex_doSigned=0.
- MUL with MUL_LAT=3, A=-1, B=1, signed -> mul_busy for 2 cycles, in_ready=0 throughout, out_valid on the 3rd cycle, ex_doSigned=1.
- LSR, shamt=63, out_ready held 0 for 4 cycles -> ex_direction=1, ex_distance=63 stable, in_ready=0 until out_ready rises, then a back-to-back capture.
- flush asserted during MUL_WAIT with a simultaneous in_valid -> no capture, EMPTY next cycle, out_valid stays 0.
- With ID_EX_FWD_EN: rn=3, fwd_mem_rd=3 with data 0xAA, and fwd_wb_rd=3 with data 0xBB -> ex_A=0xAA. rm=31 with fwd_mem_rd=31 -> ex_B=0.
- reset_n pulsed low mid-MUL -> outputs zero immediately and in_ready=1 after release.
